// File: rtl/cc_waypoint_sequencer.sv
// Waypoint sequencer: steps the 3-bit coordinate-mux select through 0..count, waiting for arrival and dwelling.
// Optional feature macro: CC_WAYPOINTSEQ_LOOP_EN (wrap to waypoint 0 instead of finishing).
module cc_waypoint_sequencer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   CC_WAYPOINTSEQ_CLOCK_50,
    input  logic                   CC_WAYPOINTSEQ_RESET_InHigh,
    input  logic                   CC_WAYPOINTSEQ_start_In,
    input  logic                   CC_WAYPOINTSEQ_abort_In,
    input  logic [2:0]             CC_WAYPOINTSEQ_count_InBus,
    input  logic [DWELL_WIDTH-1:0] CC_WAYPOINTSEQ_dwell_InBus,
    input  logic                   CC_WAYPOINTSEQ_arrived_In,
    output logic [2:0]             CC_WAYPOINTSEQ_select_OutBus,
    output logic                   CC_WAYPOINTSEQ_valid_Out,
    output logic                   CC_WAYPOINTSEQ_busy_Out,
    output logic                   CC_WAYPOINTSEQ_done_Out
);

    typedef enum logic [2:0] {IDLE, SETTLE, TRACK, DWELL, DONE} state_t;

    state_t                 state, stateNext;
    logic [2:0]             selectNext;
    logic [2:0]             countReg, countNext;
    logic [DWELL_WIDTH-1:0] dwellReg, dwellNext;
    logic [DWELL_WIDTH-1:0] dwellCnt, dwellCntNext;
    logic                   advance;
    logic                   validNext, busyNext, doneNext;

    always_ff @(posedge CC_WAYPOINTSEQ_CLOCK_50 or posedge CC_WAYPOINTSEQ_RESET_InHigh) begin
        if (CC_WAYPOINTSEQ_RESET_InHigh) begin
            state                        <= IDLE;
            CC_WAYPOINTSEQ_select_OutBus <= '0;
            countReg                     <= '0;
            dwellReg                     <= '0;
            dwellCnt                     <= '0;
            CC_WAYPOINTSEQ_valid_Out     <= 1'b0;
            CC_WAYPOINTSEQ_busy_Out      <= 1'b0;
            CC_WAYPOINTSEQ_done_Out      <= 1'b0;
        end else begin
            state                        <= stateNext;
            CC_WAYPOINTSEQ_select_OutBus <= selectNext;
            countReg                     <= countNext;
            dwellReg                     <= dwellNext;
            dwellCnt                     <= dwellCntNext;
            CC_WAYPOINTSEQ_valid_Out     <= validNext;
            CC_WAYPOINTSEQ_busy_Out      <= busyNext;
            CC_WAYPOINTSEQ_done_Out      <= doneNext;
        end
    end

    always_comb begin
        stateNext    = state;
        selectNext   = CC_WAYPOINTSEQ_select_OutBus;
        countNext    = countReg;
        dwellNext    = dwellReg;
        dwellCntNext = dwellCnt;
        advance      = 1'b0;

        case (state)
            IDLE: begin
                if (CC_WAYPOINTSEQ_start_In) begin
                    stateNext  = SETTLE;
                    selectNext = '0;
                    countNext  = CC_WAYPOINTSEQ_count_InBus;
                    dwellNext  = CC_WAYPOINTSEQ_dwell_InBus;
                end
            end
            SETTLE: stateNext = TRACK;
            TRACK: begin
                if (CC_WAYPOINTSEQ_arrived_In) begin
                    if (dwellReg != '0) begin
                        stateNext    = DWELL;
                        dwellCntNext = dwellReg;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DWELL: begin
                // Counter enters at dwell and leaves on 1, giving exactly dwell cycles here.
                dwellCntNext = dwellCnt - DWELL_WIDTH'(1);
                if (dwellCnt == DWELL_WIDTH'(1)) advance = 1'b1;
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        if (advance) begin
            if (CC_WAYPOINTSEQ_select_OutBus < countReg) begin
                selectNext = CC_WAYPOINTSEQ_select_OutBus + 3'd1;
                stateNext  = SETTLE;
            end else begin
`ifdef CC_WAYPOINTSEQ_LOOP_EN
                selectNext = '0;
                stateNext  = SETTLE;
`else
                stateNext  = DONE;
`endif
            end
        end

        // Abort overrides arrival and dwell expiry; select keeps the current waypoint.
        if (CC_WAYPOINTSEQ_abort_In && state != IDLE) begin
            stateNext  = IDLE;
            selectNext = CC_WAYPOINTSEQ_select_OutBus;
        end

        validNext = (stateNext == TRACK);
        busyNext  = (stateNext == SETTLE) || (stateNext == TRACK) || (stateNext == DWELL);
        doneNext  = (stateNext == DONE);
    end

endmodule

// File: tb/tb_cc_waypoint_sequencer.sv
// Scoreboard bench for cc_waypoint_sequencer; honours CC_WAYPOINTSEQ_LOOP_EN like the design.
module tb_cc_waypoint_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  countIn = '0;
    logic [15:0] dwellIn = '0;
    logic        arrived = 1'b0;
    logic [2:0]  selectO;
    logic        validO, busyO, doneO;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit isDone;
        int sel;
        int at;
    } ev_t;
    ev_t expQ[$];

    cc_waypoint_sequencer #(.DWELL_WIDTH(16)) dut (
        .CC_WAYPOINTSEQ_CLOCK_50     (clk),
        .CC_WAYPOINTSEQ_RESET_InHigh (rst),
        .CC_WAYPOINTSEQ_start_In     (start),
        .CC_WAYPOINTSEQ_abort_In     (abort),
        .CC_WAYPOINTSEQ_count_InBus  (countIn),
        .CC_WAYPOINTSEQ_dwell_InBus  (dwellIn),
        .CC_WAYPOINTSEQ_arrived_In   (arrived),
        .CC_WAYPOINTSEQ_select_OutBus(selectO),
        .CC_WAYPOINTSEQ_valid_Out    (validO),
        .CC_WAYPOINTSEQ_busy_Out     (busyO),
        .CC_WAYPOINTSEQ_done_Out     (doneO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit isDone, input int sel, input int at);
        ev_t e;
        e.isDone = isDone;
        e.sel    = sel;
        e.at     = at;
        expQ.push_back(e);
    endtask

    // Monitor: every valid rise or done pulse must match the oldest expected event.
    bit prevValid = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (!rst && ((validO && !prevValid) || doneO)) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpectedEvent: got valid=%0d done=%0d select=%0d expected no event (cycle %0d)",
                         validO, doneO, selectO, cyc);
            end else begin
                e = expQ.pop_front();
                chk("evKindDone", int'(doneO), int'(e.isDone));
                chk("evSelect", int'(selectO), e.sel);
                chk("evCycle", cyc, e.at);
                chk("evBusy", int'(busyO), int'(!e.isDone));
            end
        end
        prevValid = validO;
    end

    task automatic waitUntil(input int t);
        int guard = 0;
        while (cyc < t && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (expQ.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drainTimeout: got %0d pending events expected 0", expQ.size());
        end
        expQ.delete();
    endtask

    // Reference: valid rises 2 cycles after start; arrival at n with dwell d gives the next
    // valid rise at n+d+2, or the done pulse at n+d+1 on the last waypoint.
    task automatic doRun(input int k, input int d, input int aDel, input bit tieHigh,
                         input int visits, input int abortVisit, input bit pokeStart);
        int  tv, n, a, sel;
        bit  stop;
        start   = 1'b1;
        countIn = 3'(k);
        dwellIn = 16'(d);
        arrived = tieHigh;
        tv = cyc + 2;
        push(1'b0, 0, tv);
        @(posedge clk); #1;
        start   = 1'b0;
        countIn = 3'($urandom);
        dwellIn = 16'($urandom_range(0, 9));
        sel  = 0;
        stop = 1'b0;
        for (int v = 0; v < visits && !stop; v++) begin
            if (tieHigh) a = 0;
            else if (pokeStart && v == 0) a = $urandom_range(2, 4);
            else if (aDel >= 0) a = aDel;
            else a = $urandom_range(0, 4);
            n = tv + a;
            if (pokeStart && v == 0) begin
                waitUntil(tv);
                start   = 1'b1;
                countIn = 3'd7;
                waitUntil(tv + 1);
                start = 1'b0;
            end
            if (!tieHigh) begin
                waitUntil(n);
                arrived = 1'b1;
                waitUntil(n + 1);
                arrived = 1'b0;
            end
            if (v == abortVisit) begin
                waitUntil(n + d);
                abort = 1'b1;
                waitUntil(n + d + 1);
                abort = 1'b0;
                chk("abortValid", int'(validO), 0);
                chk("abortBusy", int'(busyO), 0);
                chk("abortDone", int'(doneO), 0);
                chk("abortSelect", int'(selectO), sel);
                waitUntil(n + d + 2);
                chk("abortStillIdleBusy", int'(busyO), 0);
                chk("abortNoDone", int'(doneO), 0);
                stop = 1'b1;
            end else if (sel == k) begin
`ifdef CC_WAYPOINTSEQ_LOOP_EN
                sel = 0;
                tv  = n + d + 2;
                push(1'b0, 0, tv);
`else
                push(1'b1, k, n + d + 1);
                waitUntil(n + d + 2);
                chk("idleBusy", int'(busyO), 0);
                chk("idleDone", int'(doneO), 0);
                chk("idleSelect", int'(selectO), k);
                stop = 1'b1;
`endif
            end else begin
                sel++;
                tv = n + d + 2;
                push(1'b0, sel, tv);
            end
        end
        arrived = 1'b0;
        drain();
    endtask

    task automatic resetMidTrack();
        int tv;
        start   = 1'b1;
        countIn = 3'd3;
        dwellIn = 16'd1;
        tv = cyc + 2;
        push(1'b0, 0, tv);
        @(posedge clk); #1;
        start = 1'b0;
        waitUntil(tv);
        chk("trackValidBeforeReset", int'(validO), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("asyncRstSelect", int'(selectO), 0);
        chk("asyncRstValid", int'(validO), 0);
        chk("asyncRstBusy", int'(busyO), 0);
        chk("asyncRstDone", int'(doneO), 0);
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rstSelect", int'(selectO), 0);
        chk("rstValid", int'(validO), 0);
        chk("rstBusy", int'(busyO), 0);
        chk("rstDone", int'(doneO), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postRstBusy", int'(busyO), 0);

`ifdef CC_WAYPOINTSEQ_LOOP_EN
        doRun(1, 2, -1, 1'b0, 7, 6, 1'b0);
        doRun(3, 2, -1, 1'b0, 99, 1, 1'b1);
        resetMidTrack();
        doRun(2, 1, -1, 1'b0, 5, 4, 1'b0);
        for (int i = 0; i < 4; i++)
            doRun($urandom_range(0, 7), $urandom_range(1, 4), -1, 1'b0, 10, 9, 1'b0);
`else
        doRun(2, 3, 4, 1'b0, 99, -1, 1'b0);
        doRun(7, 0, 0, 1'b1, 99, -1, 1'b0);
        doRun(0, 2, -1, 1'b0, 99, -1, 1'b0);
        doRun(3, 2, -1, 1'b0, 99, 1, 1'b1);
        resetMidTrack();
        doRun(2, 1, -1, 1'b0, 99, -1, 1'b0);
        for (int i = 0; i < 8; i++)
            doRun($urandom_range(0, 7), $urandom_range(0, 5), -1, 1'b0, 99, -1, 1'b0);
`endif
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
